// File: rtl/instruction_fetch_pkg.sv
// Shared widths and FSM encoding for the instruction fetch stage.
// FAULT only exists when FETCH_RANGE_CHECK_EN is defined.
package instruction_fetch_pkg;

    localparam int COL   = 16;  // instruction word width
    localparam int ROW_I = 16;  // ROM depth in words

    // Lowest pc bit that lies outside the ROM window (bit 5 for 16 words).
    localparam int WIN_MSB = $clog2(ROW_I) + 1;

`ifdef FETCH_RANGE_CHECK_EN
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;
`else
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1
    } fetch_state_e;
`endif

endpackage

// File: rtl/instruction_fetch_pc_gen.sv
// Next-PC selection: redirect beats increment, otherwise pc is held.
module fetch_pc_gen
    import instruction_fetch_pkg::*;
#(
    parameter int PC_STEP = 2
) (
    input  logic [COL-1:0] pc,
    input  logic           redirect,
    input  logic [COL-1:0] target,
    input  logic           advance,
    output logic [COL-1:0] pc_next
);

    // Bit 0 is forced low on both paths so pc always stays halfword aligned.
    always_comb begin
        pc_next = pc;
        if (redirect)
            pc_next = target & 16'hFFFE;
        else if (advance)
            pc_next = (pc + 16'(PC_STEP)) & 16'hFFFE;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Single-stage instruction fetch with decode backpressure and branch redirect.
// Define FETCH_RANGE_CHECK_EN to trap fetches outside the 16-word ROM window.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_STEP  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic [COL-1:0] pc,
    input  logic [COL-1:0] instruction,
    output logic [COL-1:0] if_instr,
    output logic [COL-1:0] if_pc,
    output logic           if_valid,
    input  logic           id_ready,
    input  logic           branch_taken,
    input  logic [COL-1:0] branch_target,
    output logic           fetch_fault
);

    fetch_state_e   state_q, state_d;
    logic [COL-1:0] pc_q, pc_d;
    logic [COL-1:0] if_instr_q, if_instr_d;
    logic [COL-1:0] if_pc_q, if_pc_d;
    logic           if_valid_q, if_valid_d;
    logic           redirect, capture, accept, frozen;

`ifdef FETCH_RANGE_CHECK_EN
    logic fault_q, fault_d;
    logic out_of_range;
    assign out_of_range = |pc_q[COL-1:WIN_MSB];
    assign frozen       = (state_q == FAULT);
    assign fetch_fault  = fault_q;
`else
    assign frozen       = 1'b0;
    assign fetch_fault  = 1'b0;
`endif

    // The output slot is free when empty or when decode takes it this cycle.
    assign accept = !if_valid_q || id_ready;

    always_comb begin
        state_d    = state_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        redirect   = 1'b0;
        capture    = 1'b0;
`ifdef FETCH_RANGE_CHECK_EN
        fault_d    = fault_q;
`endif
        if (!frozen) begin
            if (branch_taken) begin
                // Any word in the slot is dropped (or counted as consumed).
                redirect   = 1'b1;
                if_valid_d = 1'b0;
                state_d    = FETCH;
            end else if (accept) begin
`ifdef FETCH_RANGE_CHECK_EN
                if (out_of_range) begin
                    if_valid_d = 1'b0;
                    fault_d    = 1'b1;
                    state_d    = FAULT;
                end else
`endif
                begin
                    capture    = 1'b1;
                    if_instr_d = instruction;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    state_d    = FETCH;
                end
            end else begin
                state_d = HOLD;
            end
        end
    end

    fetch_pc_gen #(
        .PC_STEP (PC_STEP)
    ) u_pc_gen (
        .pc       (pc_q),
        .redirect (redirect),
        .target   (branch_target),
        .advance  (capture),
        .pc_next  (pc_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
        end
    end

`ifdef FETCH_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_q <= 1'b0;
        else        fault_q <= fault_d;
    end
`endif

    assign pc       = pc_q;
    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;
    assign if_valid = if_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch against a behavioural fetch model.
// Covers the FETCH_RANGE_CHECK_EN build when that macro is defined.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc, instruction, if_instr, if_pc, branch_target;
    logic        if_valid, id_ready, branch_taken, fetch_fault;
    logic [15:0] rom [16];

    int vectors = 0;
    int miscompares = 0;

`ifdef FETCH_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    // Behavioural model state
    logic [15:0] m_pc, m_instr, m_ifpc;
    logic        m_valid, m_fault;

    always #5 clk = ~clk;

    assign instruction = rom[pc[4:1]];

    instruction_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc            (pc),
        .instruction   (instruction),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_valid      (if_valid),
        .id_ready      (id_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .fetch_fault   (fetch_fault)
    );

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0; m_ifpc = 16'h0; m_valid = 1'b0; m_fault = 1'b0;
    endtask

    // One rising edge of the fetch stage, written from the rules directly.
    task automatic model_edge();
        if (m_fault) return;
        if (branch_taken) begin
            m_pc    = branch_target & 16'hFFFE;
            m_valid = 1'b0;
        end else if (!m_valid || id_ready) begin
            if (RC && m_pc >= 16'h0020) begin
                m_valid = 1'b0;
                m_fault = 1'b1;
            end else begin
                m_instr = rom[m_pc[4:1]];
                m_ifpc  = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 16'd2;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 16; k++) rom[k] = 16'h1000 + 16'(k);
        id_ready = 1'b1; branch_taken = 1'b0; branch_target = 16'h0;
        rst_n = 1'b0;
        model_reset();
        #3;
        vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL reset_pc: got %h want 0000", pc); end
        vectors++; if (if_instr !== 16'h0000) begin miscompares++; $display("FAIL reset_if_instr: got %h want 0000", if_instr); end
        vectors++; if (if_pc !== 16'h0000) begin miscompares++; $display("FAIL reset_if_pc: got %h want 0000", if_pc); end
        vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
        vectors++; if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
    endtask

    task automatic test_sequential();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL seq_valid[%0d]: got %b want 1", k, if_valid); end
            vectors++; if (if_pc !== 16'(2*k)) begin miscompares++; $display("FAIL seq_if_pc[%0d]: got %h want %h", k, if_pc, 16'(2*k)); end
            vectors++; if (if_instr !== 16'h1000 + 16'(k)) begin miscompares++; $display("FAIL seq_if_instr[%0d]: got %h want %h", k, if_instr, 16'h1000 + 16'(k)); end
        end
    endtask

    task automatic test_hold();
        do_reset();
        id_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        vectors++; if (if_pc !== 16'h0004) begin miscompares++; $display("FAIL hold_start_pc: got %h want 0004", if_pc); end
        id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++; if (if_pc !== 16'h0004 || if_instr !== 16'h1002 || if_valid !== 1'b1)
                begin miscompares++; $display("FAIL hold_frozen[%0d]: got pc=%h instr=%h v=%b want 0004/1002/1", k, if_pc, if_instr, if_valid); end
            vectors++; if (pc !== 16'h0006) begin miscompares++; $display("FAIL hold_pc[%0d]: got %h want 0006", k, pc); end
        end
        id_ready = 1'b1;
        tick();
        vectors++; if (if_pc !== 16'h0006 || if_instr !== 16'h1003)
            begin miscompares++; $display("FAIL hold_release: got pc=%h instr=%h want 0006/1003", if_pc, if_instr); end
    endtask

    task automatic test_branch();
        id_ready = 1'b0; branch_taken = 1'b1; branch_target = 16'h0013;
        tick();
        branch_taken = 1'b0;
        vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL br_valid: got %b want 0", if_valid); end
        vectors++; if (pc !== 16'h0012) begin miscompares++; $display("FAIL br_pc: got %h want 0012", pc); end
        tick();
        vectors++; if (if_pc !== 16'h0012 || if_valid !== 1'b1 || if_instr !== rom[9])
            begin miscompares++; $display("FAIL br_target: got pc=%h v=%b instr=%h want 0012/1/%h", if_pc, if_valid, if_instr, rom[9]); end
        // Branch coinciding with a transfer: no stale word before the target.
        id_ready = 1'b1; branch_taken = 1'b1; branch_target = 16'h0004;
        tick();
        branch_taken = 1'b0;
        vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL br_xfer_valid: got %b want 0", if_valid); end
        tick();
        vectors++; if (if_pc !== 16'h0004 || if_instr !== rom[2])
            begin miscompares++; $display("FAIL br_xfer_target: got pc=%h instr=%h want 0004/%h", if_pc, if_instr, rom[2]); end
    endtask

`ifndef FETCH_RANGE_CHECK_EN
    task automatic test_wrap();
        id_ready = 1'b1; branch_taken = 1'b1; branch_target = 16'hFFFE;
        tick();
        branch_taken = 1'b0;
        tick();
        vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL wrap_pc: got %h want 0000", pc); end
        vectors++; if (if_instr !== rom[15] || if_pc !== 16'hFFFE)
            begin miscompares++; $display("FAIL wrap_instr: got instr=%h pc=%h want %h/fffe", if_instr, if_pc, rom[15]); end
    endtask
`else
    task automatic test_fault();
        do_reset();
        id_ready = 1'b1; branch_taken = 1'b1; branch_target = 16'h0020;
        tick();
        branch_taken = 1'b0;
        tick();
        vectors++; if (fetch_fault !== 1'b1 || if_valid !== 1'b0)
            begin miscompares++; $display("FAIL fault_enter: got f=%b v=%b want 1/0", fetch_fault, if_valid); end
        branch_taken = 1'b1; branch_target = 16'h0004;
        tick();
        branch_taken = 1'b0;
        tick();
        vectors++; if (fetch_fault !== 1'b1 || if_valid !== 1'b0 || pc !== 16'h0020)
            begin miscompares++; $display("FAIL fault_sticky: got f=%b v=%b pc=%h want 1/0/0020", fetch_fault, if_valid, pc); end
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #2;
        vectors++; if (fetch_fault !== 1'b0 || if_valid !== 1'b0 || pc !== 16'h0000)
            begin miscompares++; $display("FAIL fault_reset: got f=%b v=%b pc=%h want 0/0/0000", fetch_fault, if_valid, pc); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++; if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_instr !== rom[0])
            begin miscompares++; $display("FAIL fault_restart: got v=%b pc=%h instr=%h want 1/0000/%h", if_valid, if_pc, if_instr, rom[0]); end
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 16; k++) rom[k] = 16'($urandom);
        do_reset();
        for (int n = 0; n < 400; n++) begin
            id_ready      = ($urandom_range(0, 3) != 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            branch_target = RC ? 16'($urandom_range(0, 35)) : 16'($urandom);
            tick();
            vectors++; if (pc !== m_pc) begin miscompares++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, pc, m_pc); end
            vectors++; if (if_valid !== m_valid) begin miscompares++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, if_valid, m_valid); end
            vectors++; if (m_valid && (if_instr !== m_instr || if_pc !== m_ifpc))
                begin miscompares++; $display("FAIL rnd_slot[%0d]: got %h@%h want %h@%h", n, if_instr, if_pc, m_instr, m_ifpc); end
            vectors++; if (fetch_fault !== m_fault) begin miscompares++; $display("FAIL rnd_fault[%0d]: got %b want %b", n, fetch_fault, m_fault); end
            if (m_fault && $urandom_range(0, 3) == 0) do_reset();
        end
        branch_taken = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        id_ready = 1'b1;
        tick();
        tick();
        id_ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++; if (pc !== 16'h0000 || if_instr !== 16'h0 || if_pc !== 16'h0)
            begin miscompares++; $display("FAIL areset_regs: got pc=%h instr=%h ifpc=%h want 0", pc, if_instr, if_pc); end
        vectors++; if (if_valid !== 1'b0 || fetch_fault !== 1'b0)
            begin miscompares++; $display("FAIL areset_flags: got v=%b f=%b want 0/0", if_valid, fetch_fault); end
        @(negedge clk);
        rst_n = 1'b1;
        id_ready = 1'b1;
        tick();
        vectors++; if (if_valid !== 1'b1 || if_pc !== 16'h0000)
            begin miscompares++; $display("FAIL areset_first: got v=%b pc=%h want 1/0000", if_valid, if_pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold();
        test_branch();
`ifndef FETCH_RANGE_CHECK_EN
        test_wrap();
`else
        test_fault();
`endif
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
